div_restoring_seq: RTL

- Sequential restoring shift-subtract divider; the inverse partner of the team's 4-bit add-and-shift multiplier.
- Takes a 2N-bit dividend and an N-bit divisor.
- Produces an N-bit quotient and an N-bit remainder over N iteration cycles, with overflow and divide-by-zero detection.
- Uses the same start/ready handshake and the same resultBus packing convention as the multiplier, so both can sit behind one operand/result bus in the arithmetic unit.

---
 rtl/div_pkg.sv | 26 ++
 rtl/div_restoring_dp.sv | 101 ++++++++++
 rtl/div_restoring_seq.sv | 99 +++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared constants for the restoring divider: state encoding, default width,
// and the field layout of the packed result bus.
package div_pkg;

   localparam int DIV_N = 4;

   localparam logic [3:0] ST_IDLE = 4'b0001;
   localparam logic [3:0] ST_INIT = 4'b0010;
   localparam logic [3:0] ST_ITER = 4'b0100;
   localparam logic [3:0] ST_DONE = 4'b1000;

   typedef enum logic [3:0] {
      S_IDLE = ST_IDLE,
      S_INIT = ST_INIT,
      S_ITER = ST_ITER,
      S_DONE = ST_DONE
   } state_t;

   // resultBus = {remainder, quotient}: quotient at bit 0, remainder at bit N.
   localparam int RES_QUO_LSB = 0;

   function automatic int res_rem_lsb(input int n);
      return n;
   endfunction

endpackage

// File: rtl/div_restoring_dp.sv
// Restoring-divider datapath: partial remainder P, dividend/quotient shifter A,
// divisor B, the N+1-bit compare/subtract, and overflow / zero-divisor flags.
module div_restoring_dp
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic           check,
   input  logic           step,
   input  logic           finalize,
   input  logic [2*N-1:0] a_in,
   input  logic [N-1:0]   b_in,
   output logic           ovf,
   output logic           dz,
   output logic [2*N-1:0] result
);

   logic [N:0]     p_q, p_d;
   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic           ovf_q, ovf_d;
   logic           dz_q, dz_d;
   logic [2*N-1:0] res_q, res_d;

   logic [N:0]     p_sh;
   logic [N:0]     b_ext;
   logic           take;
   logic [N:0]     p_step;
   logic [N-1:0]   a_step;
   logic           dz_det;
   logic           fit_ovf;

   always_comb begin
      // P[N] is zero between steps, so the shift only needs P[N-1:0].
      p_sh    = {p_q[N-1:0], a_q[N-1]};
      b_ext   = {1'b0, b_q};
      take    = (p_sh >= b_ext);
      p_step  = take ? (p_sh - b_ext) : p_sh;
      a_step  = {a_q[N-2:0], take};
      dz_det  = (b_q == '0);
      fit_ovf = (p_q >= b_ext);
   end

   always_comb begin
      p_d   = p_q;
      a_d   = a_q;
      b_d   = b_q;
      ovf_d = ovf_q;
      dz_d  = dz_q;
      res_d = res_q;
      if (load) begin
         p_d   = {1'b0, a_in[2*N-1:N]};
         a_d   = a_in[N-1:0];
         b_d   = b_in;
         ovf_d = 1'b0;
         dz_d  = 1'b0;
      end
      if (check) begin
         ovf_d = dz_det | fit_ovf;
         dz_d  = dz_det;
      end
      if (step) begin
         p_d = p_step;
         a_d = a_step;
      end
      if (finalize) begin
         if (ovf_q) begin
            res_d = '0;
         end else begin
            res_d[RES_QUO_LSB +: N]    = a_step;
            res_d[res_rem_lsb(N) +: N] = p_step[N-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p_q   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         ovf_q <= 1'b0;
         dz_q  <= 1'b0;
         res_q <= '0;
      end else begin
         p_q   <= p_d;
         a_q   <= a_d;
         b_q   <= b_d;
         ovf_q <= ovf_d;
         dz_q  <= dz_d;
         res_q <= res_d;
      end
   end

   assign ovf    = ovf_q;
   assign dz     = dz_q;
   assign result = res_q;

endmodule

// File: rtl/div_restoring_seq.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor in N steps,
// start/ready handshake, {remainder, quotient} on resultBus.
module div_restoring_seq
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [2*N-1:0] ABus,
   input  logic [N-1:0]   BBus,
   output logic           ready,
   output logic           done,
   output logic           ovf,
   output logic           dz,
   output logic [2*N-1:0] resultBus
);

   localparam int CW = $clog2(N + 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          load, check, step, finalize;
   logic          last_step;

   div_restoring_dp #(.N(N)) u_dp (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .check    (check),
      .step     (step),
      .finalize (finalize),
      .a_in     (ABus),
      .b_in     (BBus),
      .ovf      (ovf),
      .dz       (dz),
      .result   (resultBus)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      load      = 1'b0;
      check     = 1'b0;
      step      = 1'b0;
      finalize  = 1'b0;
      last_step = (cnt_q == CW'(N - 1));
      case (state_q)
         S_IDLE: begin
            if (start) begin
               load    = 1'b1;
               cnt_d   = '0;
               state_d = S_INIT;
            end
         end
         // The fit / zero check is registered here and acted on in the first
         // ITER cycle, so an overflow leaves ITER without taking any step.
         S_INIT: begin
            check   = 1'b1;
            cnt_d   = '0;
            state_d = S_ITER;
         end
         S_ITER: begin
            if (ovf) begin
               finalize = 1'b1;
               state_d  = S_DONE;
            end else begin
               step  = 1'b1;
               cnt_d = cnt_q + CW'(1);
               if (last_step) begin
                  finalize = 1'b1;
                  state_d  = S_DONE;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ready = (state_q == S_IDLE);
   assign done  = (state_q == S_DONE);

endmodule
